// File: rtl/instr_field_router_if.sv
// Bundle of the router's input handshake, per-channel output handshakes
// and error reporting. The master side is the decoder/consumer
// environment and the slave side is the router.
//
// Handshake rule for every valid/ready pair: a transfer happens on a
// rising clock edge where valid and ready are both 1. The sender holds
// the payload stable while valid=1 and ready=0.
interface instr_field_router_if #(
   parameter int DATA_W = 12,
   parameter int NUM_CH = 2,
   parameter int SEL_W  = 1
);
   logic                     in_valid;
   logic                     in_ready;
   logic [SEL_W-1:0]         in_sel;
   logic [DATA_W-1:0]        in_data;
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH-1:0]        ch_ready;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic                     err_sel;
   logic [7:0]               err_cnt;

   modport master (
      output in_valid, in_sel, in_data, ch_ready,
      input  in_ready, ch_valid, ch_data, err_sel, err_cnt
   );

   modport slave (
      input  in_valid, in_sel, in_data, ch_ready,
      output in_ready, ch_valid, ch_data, err_sel, err_cnt
   );
endinterface

// File: rtl/instr_field_router.sv
// Steers one instruction field per cycle to one of NUM_CH single-entry
// destination channels (data address, ALU opcode, immediate, branch
// target, ...). Each channel is a one-deep register with its own
// valid/ready output; a full channel that is drained in the same cycle
// can take a new field, so a steady stream sees no bubbles.
// Out-of-range selects are accepted, dropped and counted.
//
// The only state machines are the per-channel EMPTY/FULL flags, which
// are exactly the ch_valid outputs, so channel state is directly visible.
module instr_field_router #(
   parameter int DATA_W    = 12,
   parameter int NUM_CH    = 2,
   parameter int SEL_W     = 1,
   parameter int HOLD_LAST = 1
) (
   input logic                clk,
   input logic                rst,
   instr_field_router_if.slave bus
);

   localparam logic CH_EMPTY = 1'b0;
   localparam logic CH_FULL  = 1'b1;

   logic [NUM_CH-1:0]        ch_valid_q, ch_valid_d;
   logic [NUM_CH*DATA_W-1:0] ch_data_q, ch_data_d;
   logic                     err_sel_q, err_sel_d;
   logic [7:0]               err_cnt_q, err_cnt_d;

   logic [NUM_CH-1:0]        sel_hit;
   logic [NUM_CH-1:0]        load;
   logic [NUM_CH-1:0]        drain;
   logic                     in_range;
   logic                     sel_ready;
   logic                     accept;

   // One-hot decode of the select; all-zero means out of range.
   always_comb begin
      sel_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sel_hit[i] = (bus.in_sel == i[SEL_W-1:0]);
      end
   end

   assign in_range  = |sel_hit;
   // Selected channel can take data if it is empty or being drained now.
   assign sel_ready = |(sel_hit & (~ch_valid_q | bus.ch_ready));
   // Out-of-range fields are always taken so they can be discarded.
   assign bus.in_ready = !rst && (!in_range || sel_ready);
   assign accept    = bus.in_valid && bus.in_ready;
   assign load      = sel_hit & {NUM_CH{accept}};
   assign drain     = ch_valid_q & bus.ch_ready;

   // Per-channel next state: load wins over drain so a simultaneous
   // drain+refill keeps the channel FULL with the new field.
   always_comb begin
      ch_valid_d = ch_valid_q;
      ch_data_d  = ch_data_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (load[i]) begin
            ch_valid_d[i]                 = CH_FULL;
            ch_data_d[i*DATA_W +: DATA_W] = bus.in_data;
         end else if (drain[i]) begin
            ch_valid_d[i] = CH_EMPTY;
            if (HOLD_LAST == 0) begin
               ch_data_d[i*DATA_W +: DATA_W] = '0;
            end
         end
      end
   end

   // Error pulse and saturating drop counter for out-of-range fields.
   always_comb begin
      err_sel_d = accept && !in_range;
      err_cnt_d = err_cnt_q;
      if (err_sel_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   // State registers; reset discards any entry pending in a channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_valid_q <= '0;
         ch_data_q  <= '0;
         err_sel_q  <= 1'b0;
         err_cnt_q  <= 8'd0;
      end else begin
         ch_valid_q <= ch_valid_d;
         ch_data_q  <= ch_data_d;
         err_sel_q  <= err_sel_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.ch_valid = ch_valid_q;
   assign bus.ch_data  = ch_data_q;
   assign bus.err_sel  = err_sel_q;
   assign bus.err_cnt  = err_cnt_q;

endmodule

// File: doc/instr_field_router.md
Name: instr_field_router

Overview:
- Parametrised successor to the two-way address/ALU-opcode demux in the fetch/decode path.
- Accepts one instruction field per cycle on a valid/ready input and steers it to one of NUM_CH destination channels, each holding one entry.
- Destinations include the data-address register, ALU opcode, immediate and branch target.
- Each channel has its own valid/ready output handshake. Backpressure propagates to the decoder, so fields are never overwritten or lost.
- Out-of-range selects are dropped and counted.

Parameters:
- DATA_W, 12, width of the routed field (12 covers data_addr; 8-bit opcodes are zero-extended by the sender).
- NUM_CH, 2, number of destination channels; legal range 2..16.
- SEL_W, 1, width of the select field; must satisfy 2**SEL_W >= NUM_CH.
- HOLD_LAST, 1, when 1 a channel keeps its last data after drain; when 0 its data clears to 0 on drain.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input field valid.
- in_ready  out  1  router can accept the field; combinational.
- in_sel  in  SEL_W  destination channel index.
- in_data  in  DATA_W  field payload.
- ch_valid  out  NUM_CH  per-channel entry valid; registered.
- ch_ready  in  NUM_CH  per-channel consumer ready.
- ch_data  out  NUM_CH*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W]; registered.
- err_sel  out  1  one-cycle pulse, the cycle after an out-of-range select is accepted.
- err_cnt  out  8  saturating count of dropped out-of-range fields.

Behaviour:
- Reset (rst=1 at the clock edge):
  - ch_valid=0, ch_data=0, err_sel=0, err_cnt=0.
  - in_ready is forced to 0 while rst is high.
  - Reset takes effect mid-transfer; an entry pending at that time is discarded.
- Accept:
  - A field is accepted when in_valid && in_ready at the clock edge.
  - A select is in range when in_sel < NUM_CH.
- in_ready:
  - Out-of-range in_sel: in_ready=1.
  - In-range in_sel: in_ready = !ch_valid[in_sel] || ch_ready[in_sel].
  - This is the pass-through ready form: a full channel accepts a new field in the same cycle it is drained.
- Latency:
  - An accepted in-range field appears on ch_data[in_sel] with ch_valid[in_sel]=1 on the next cycle (1-cycle latency).
  - Other channels are unaffected.
- Drain:
  - ch_valid[i] && ch_ready[i] at the edge completes the transfer.
  - If there is no refill of channel i in that cycle, ch_valid[i] goes to 0 next cycle.
  - On that drain, ch_data[i] holds its value if HOLD_LAST=1 and clears to 0 if HOLD_LAST=0.
- Simultaneous drain and refill of the same channel: ch_valid[i] stays 1 and ch_data[i] takes the new field; no bubble.
- ch_ready[i] with ch_valid[i]=0 has no effect.
- Stability: while ch_valid[i]=1 and ch_ready[i]=0, ch_data[i] must not change.
- Independence: any number of channels may drain in the same cycle; at most one channel loads per cycle.
- Out-of-range select:
  - The field is discarded and no channel changes.
  - err_sel=1 on the next cycle only.
  - err_cnt increments by 1 and saturates at 255 with no wrap.
- in_data and in_sel must be held stable by the sender while in_valid=1 && in_ready=0; the router does not latch them before acceptance.
- No internal FSM beyond per-channel full/empty state. Each channel behaves as a 2-state machine:
  - EMPTY->FULL on load.
  - FULL->EMPTY on drain without load.
  - FULL->FULL on drain with load, or on stall.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, all ch_valid=0, ch_data=0, err_cnt=0; after release in_ready=1.
- Basic steer, NUM_CH=2, DATA_W=12:
  - Send sel=0 data=12'hA5C with ch_ready=2'b11 -> next cycle ch_valid=2'b01, ch_data[11:0]=12'hA5C.
  - Then sel=1 data=12'h03F -> ch_data[23:12]=12'h03F.
- Backpressure, ch_ready[0]=0:
  - Send sel=0 12'h111, then sel=0 12'h222 -> in_ready=0 on the second field and channel 0 holds 12'h111.
  - Raise ch_ready[0] -> 12'h222 loads in the same cycle 12'h111 drains; ch_valid[0] never drops.
- HOLD_LAST sweep:
  - HOLD_LAST=0: drain channel 1 holding 12'h3FF with no refill -> ch_valid[1]=0, ch_data[23:12]=0.
  - HOLD_LAST=1: same stimulus -> ch_valid[1]=0, ch_data[23:12]=12'h3FF.
- Out-of-range, NUM_CH=3, SEL_W=2: send sel=3 -> in_ready=1, no ch_valid change, err_sel pulses once, err_cnt=1; 300 such fields -> err_cnt=255.
- Random stress, NUM_CH=4: 10k cycles of random in_valid/in_sel/ch_ready -> scoreboard shows in-order, loss-free delivery per channel and ch_data stable while stalled.
